instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetches instructions from a 16-bit-wide instruction memory and presents them to `instruction_format_extended`. Each instruction is delivered as either a 16-bit standard word or an assembled 32-bit extended word, with a valid/ready handshake toward decode. A 16-bit instruction whose low 6 bits equal the escape marker `6'h3F` is the first half of an extended instruction. The unit then fetches the next halfword and asserts `use_extended`. Sits between program memory and the format/decode stage; owns the PC.

## Interface
Parameters:
- `ADDR_W`, 8: halfword address width; PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  memory request; level-held until accepted.
- `imem_addr`  out  ADDR_W  halfword address; stable while `imem_req` is high.
- `imem_data`  in  16  read data; sampled only when `imem_req && imem_valid`.
- `imem_valid`  in  1  response strobe; may assert in the same cycle as `imem_req`.
- `redirect_valid`  in  1  branch/jump redirect.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `out_valid`  out  1  instruction available.
- `out_ready`  in  1  decode accepts.
- `instruction_16`  out  16  first (or only) halfword.
- `instruction_32`  out  32  `{hi_half, lo_half}` if extended, else `{instruction_16, 16'h0000}`.
- `use_extended`  out  1  the word is extended.
- `pc_out`  out  ADDR_W  address of the first halfword of the presented instruction.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, HOLD.
- IDLE:
  - Entered on reset.
  - Goes to FETCH_LO unconditionally in the next cycle.
- FETCH_LO:
  - `imem_req`=1, `imem_addr`=pc.
  - On accept (`imem_req && imem_valid`), latch the halfword and set pc=pc+1.
  - If `imem_data[5:0]==6'h3F`, go to FETCH_HI.
  - Otherwise load the output register and go to HOLD.
- FETCH_HI:
  - `imem_req`=1, `imem_addr`=pc.
  - On accept, set pc=pc+1, assemble the 32-bit word, set `use_extended`=1 and go to HOLD.
- HOLD:
  - `out_valid`=1 and `imem_req`=0.
  - On `out_ready`, clear `out_valid` and go to FETCH_LO.
  - Outputs stay stable until the handshake completes.
- Redirect has priority in every state, including IDLE. Its effects in the next cycle:
  - pc=`redirect_pc`.
  - State is FETCH_LO.
  - `out_valid`=0 and `use_extended`=0.
  - Any halfword accepted in the redirect cycle is discarded.
  - A partially assembled extended word is dropped.
- Redirect and an `out_ready` handshake in the same cycle: the presented instruction counts as consumed, then the redirect applies.
- Wrap-around: pc increments modulo 2^ADDR_W. An extended word whose first half is at the last address fetches its second half from address 0. `pc_out` reports the last address.
- Memory contract: a response counts only in a cycle where `imem_req` is high. Dropping `imem_req` aborts the request, and the memory must not deliver a stale response later.
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `out_valid`=0, `use_extended`=0.
  - `instruction_16`=0, `instruction_32`=0.
  - `pc_out`=RESET_PC.
  - State IDLE.
- Reset asserted mid-fetch or mid-hold overrides everything, including redirect.

## Timing
- The first `imem_req` is issued one cycle after `rst` deasserts (IDLE→FETCH_LO).
- Zero-wait memory, measured from the cycle the FETCH_LO request is accepted:
  - 16-bit instruction: `out_valid` in the next cycle.
  - Extended instruction: FETCH_HI is accepted the following cycle, and `out_valid` comes 2 cycles after the FETCH_LO accept.
- Each wait cycle on `imem_valid` adds one cycle.
- Throughput with `out_ready` tied high and zero wait:
  - One 16-bit instruction every 2 cycles.
  - One extended instruction every 3 cycles.
- Redirect to first request: `imem_req` with the new address appears in the cycle after `redirect_valid`.
- All outputs are registered, except `imem_req` and `imem_addr`, which are decoded from state and pc flops with no input paths.

## Configuration
- `IFETCH_EXTENDED_EN`
  - Defined: escape detection and the FETCH_HI state are present, as described above.
  - Undefined: every halfword is a complete instruction; `6'h3F` has no special meaning. FETCH_HI is not built, `use_extended` is tied 0, and `instruction_32` = `{instruction_16, 16'h0000}`.

## Structure
- Package `ifetch_pkg` holds:
  - the state encoding (IDLE, FETCH_LO, FETCH_HI, HOLD);
  - the constant `EXT_ESCAPE = 6'h3F`;
  - the halfword width constant 16.
- `instruction_format_extended` imports `EXT_ESCAPE` from the same package.
- Single module; no sub-module. The output register and FSM are small enough to keep flat.

## Test plan
- Reset, then memory holds 16'h1234 at address 0 with zero wait → `imem_req` in the cycle after reset release. `out_valid` follows one cycle after accept, with `instruction_16`=16'h1234, `use_extended`=0, `pc_out`=0.
- Address 4 = 16'h203F, address 5 = 16'hBEEF → `instruction_32`=32'h203FBEEF, `use_extended`=1, `pc_out`=4; the next fetch is from address 6.
- Hold `out_ready`=0 for 5 cycles while `out_valid`=1 → outputs stable and `imem_req`=0 throughout. The fetch from the next address begins the cycle after `out_ready`=1.
- `redirect_valid` with `redirect_pc`=8'h40 in the FETCH_HI accept cycle → the extended word is never presented. The next `imem_addr`=8'h40 and `out_valid` stays 0 until that fetch completes.
- `ADDR_W`=8, extended first half at 8'hFF → second half is fetched from 8'h00, `pc_out`=8'hFF, and the next fetch is from 8'h01.
- Build without `IFETCH_EXTENDED_EN`, memory word 16'h203F → presented as a 16-bit instruction with `use_extended`=0; the next fetch is from pc+1.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and the format stage.
package ifetch_pkg;

  localparam int HW_W = 16;
  localparam logic [5:0] EXT_ESCAPE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_e;

  function automatic logic is_escape(input logic [HW_W-1:0] hw);
    return hw[5:0] == EXT_ESCAPE;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Halfword fetch FSM owning the PC; presents 16-bit or assembled 32-bit words to decode.
// Define IFETCH_EXTENDED_EN to build escape detection and the FETCH_HI state.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [HW_W-1:0]   imem_data,
  input  logic              imem_valid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HW_W-1:0]   instruction_16,
  output logic [31:0]       instruction_32,
  output logic              use_extended,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              vld_q, vld_d;
  logic [HW_W-1:0]   i16_q, i16_d;
  logic              accept;
`ifdef IFETCH_EXTENDED_EN
  logic [31:0]       i32_q, i32_d;
  logic              ext_q, ext_d;
`endif

  // Request/address come straight from flops so memory sees no input paths.
  assign imem_req  = (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    i16_d    = i16_q;
`ifdef IFETCH_EXTENDED_EN
    i32_d    = i32_q;
    ext_d    = ext_q;
`endif
    case (state_q)
      IDLE: state_d = FETCH_LO;
      FETCH_LO: begin
        if (accept) begin
          pc_d     = pc_q + ADDR_W'(1);
          i16_d    = imem_data;
          pc_out_d = pc_q;
`ifdef IFETCH_EXTENDED_EN
          if (is_escape(imem_data)) begin
            state_d = FETCH_HI;
          end else begin
            i32_d   = {imem_data, 16'h0000};
            ext_d   = 1'b0;
            vld_d   = 1'b1;
            state_d = HOLD;
          end
`else
          vld_d   = 1'b1;
          state_d = HOLD;
`endif
        end
      end
`ifdef IFETCH_EXTENDED_EN
      FETCH_HI: begin
        // First half already sits in i16_q; pc wraps naturally for the second half.
        if (accept) begin
          pc_d    = pc_q + ADDR_W'(1);
          i32_d   = {i16_q, imem_data};
          ext_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
`endif
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = FETCH_LO;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect wins over any accept or handshake in the same cycle.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = FETCH_LO;
      vld_d   = 1'b0;
`ifdef IFETCH_EXTENDED_EN
      ext_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RST_PC;
      pc_out_q <= RST_PC;
      vld_q    <= 1'b0;
      i16_q    <= '0;
`ifdef IFETCH_EXTENDED_EN
      i32_q    <= '0;
      ext_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      i16_q    <= i16_d;
`ifdef IFETCH_EXTENDED_EN
      i32_q    <= i32_d;
      ext_q    <= ext_d;
`endif
    end
  end

  assign out_valid      = vld_q;
  assign instruction_16 = i16_q;
  assign pc_out         = pc_out_q;
`ifdef IFETCH_EXTENDED_EN
  assign instruction_32 = i32_q;
  assign use_extended   = ext_q;
`else
  assign instruction_32 = {i16_q, 16'h0000};
  assign use_extended   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus redirect/reset sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instruction_16;
  logic [31:0] instruction_32;
  logic        use_extended;
  logic [7:0]  pc_out;

  logic [15:0] mem [256];
  logic        mem_ok;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_16(instruction_16), .instruction_32(instruction_32),
    .use_extended(use_extended), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Zero-wait memory unless the bench stalls it with mem_ok.
  assign imem_data  = mem[imem_addr];
  assign imem_valid = imem_req & mem_ok;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] lo;
    logic [15:0] hi;
    int          waits;
    int          lat;
    logic [31:0] i32;
    logic        ext;
    logic [7:0]  nxt;
  } vec_t;

  vec_t vt [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0; mem_ok = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;

`ifdef IFETCH_EXTENDED_EN
    vt[0] = '{8'h10, 16'h0041, 16'h0000, 0, 1, 32'h00410000, 1'b0, 8'h11};
    vt[1] = '{8'h04, 16'h203F, 16'hBEEF, 0, 2, 32'h203FBEEF, 1'b1, 8'h06};
    vt[2] = '{8'h20, 16'hA5C3, 16'h0000, 2, 3, 32'hA5C30000, 1'b0, 8'h21};
    vt[3] = '{8'hFF, 16'h12FF, 16'h5678, 0, 2, 32'h12FF5678, 1'b1, 8'h01};
    vt[4] = '{8'h30, 16'h003E, 16'h0000, 1, 2, 32'h003E0000, 1'b0, 8'h31};
    vt[5] = '{8'h50, 16'hFFFF, 16'h0001, 1, 3, 32'hFFFF0001, 1'b1, 8'h52};
`else
    vt[0] = '{8'h10, 16'h0041, 16'h0000, 0, 1, 32'h00410000, 1'b0, 8'h11};
    vt[1] = '{8'h04, 16'h203F, 16'hBEEF, 0, 1, 32'h203F0000, 1'b0, 8'h05};
    vt[2] = '{8'h20, 16'hA5C3, 16'h0000, 2, 3, 32'hA5C30000, 1'b0, 8'h21};
    vt[3] = '{8'hFF, 16'h12FF, 16'h5678, 0, 1, 32'h12FF0000, 1'b0, 8'h00};
    vt[4] = '{8'h30, 16'h003E, 16'h0000, 1, 2, 32'h003E0000, 1'b0, 8'h31};
    vt[5] = '{8'h50, 16'hFFFF, 16'h0001, 1, 2, 32'hFFFF0000, 1'b0, 8'h51};
`endif

    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_ext", use_extended, 0);
    chk("rst_i16", instruction_16, 0);
    chk("rst_i32", instruction_32, 0);
    chk("rst_pcout", pc_out, 0);

    // Reset must override a concurrent redirect.
    redirect_valid = 1'b1; redirect_pc = 8'h70;
    tick();
    redirect_valid = 1'b0;
    chk("rst_vs_redir_req", imem_req, 0);
    chk("rst_vs_redir_addr", imem_addr, 0);

    rst = 1'b0;
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    tick();
    chk("first_vld", out_valid, 1);
    chk("first_i16", instruction_16, 16'h1234);
    chk("first_i32", instruction_32, 32'h12340000);
    chk("first_ext", use_extended, 0);
    chk("first_pcout", pc_out, 0);

    // Back-pressure: outputs frozen and no memory traffic.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_vld", out_valid, 1);
      chk("hold_i16", instruction_16, 16'h1234);
      chk("hold_req", imem_req, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_hs_vld", out_valid, 0);
    chk("after_hs_req", imem_req, 1);
    chk("after_hs_addr", imem_addr, 1);

    for (int v = 0; v < 6; v++) begin
      int n;
      mem[vt[v].pc] = vt[v].lo;
      mem[8'(vt[v].pc + 8'd1)] = vt[v].hi;
      redirect_to(vt[v].pc);
      chk("vec_addr", imem_addr, {24'h0, vt[v].pc});
      n = 0;
      while (!out_valid && n < 20) begin
        mem_ok = (n >= vt[v].waits);
        tick();
        n++;
      end
      mem_ok = 1'b1;
      chk("vec_lat", n, vt[v].lat);
      chk("vec_i16", instruction_16, vt[v].lo);
      chk("vec_i32", instruction_32, vt[v].i32);
      chk("vec_ext", use_extended, vt[v].ext);
      chk("vec_pcout", pc_out, {24'h0, vt[v].pc});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("vec_vld_clr", out_valid, 0);
      chk("vec_next", imem_addr, {24'h0, vt[v].nxt});
    end

`ifdef IFETCH_EXTENDED_EN
    // Redirect on the second-half accept drops the extended word.
    mem[8'h04] = 16'h203F; mem[8'h05] = 16'hBEEF; mem[8'h40] = 16'h0042;
    redirect_to(8'h04);
    tick();
    chk("hi_addr", imem_addr, 8'h05);
    redirect_to(8'h40);
    chk("hi_redir_addr", imem_addr, 8'h40);
    chk("hi_redir_vld", out_valid, 0);
    chk("hi_redir_ext", use_extended, 0);
    tick();
    chk("hi_redir_vld2", out_valid, 1);
    chk("hi_redir_i16", instruction_16, 16'h0042);
    chk("hi_redir_ext2", use_extended, 0);
    chk("hi_redir_pcout", pc_out, 8'h40);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    // Handshake and redirect together: consumed, then redirected.
    mem[8'h60] = 16'h0061;
    redirect_to(8'h60);
    tick();
    chk("rr_vld", out_valid, 1);
    out_ready = 1'b1;
    redirect_to(8'h80);
    out_ready = 1'b0;
    chk("rr_vld_clr", out_valid, 0);
    chk("rr_addr", imem_addr, 8'h80);
    chk("rr_req", imem_req, 1);

    // Redirect taken straight out of IDLE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem[8'h90] = 16'h0091;
    redirect_to(8'h90);
    chk("idle_redir_addr", imem_addr, 8'h90);
    tick();
    chk("idle_redir_vld", out_valid, 1);
    chk("idle_redir_i16", instruction_16, 16'h0091);

    // Reset during HOLD beats a concurrent redirect.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hA0;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_i16", instruction_16, 0);
    chk("midrst_pcout", pc_out, 0);
    chk("midrst_req", imem_req, 0);
    chk("midrst_addr", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
